// File: rtl/munoc_write_request_packetizer.sv
// munoc_write_request_packetizer: packs an AXI AW+W write request into header and beat flits on an FNI link
module munoc_write_request_packetizer #(
  parameter int BW_FLIT    = 32,
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int BW_ID      = 4,
  parameter int BW_NODE_ID = 4
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic [BW_NODE_ID-1:0]   src_node_id,
  input  logic [BW_NODE_ID-1:0]   awdst_node_id,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [BW_ID-1:0]        awid,
  input  logic [BW_ADDR-1:0]      awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [BW_DATA-1:0]      wdata,
  input  logic [BW_DATA/8-1:0]    wstrb,
  input  logic                    wlast,
  output logic [BW_FLIT+2:0]      fni_link,
  input  logic                    fni_ready,
  output logic                    protocol_error
);
  localparam int NB         = BW_DATA / 8;
  localparam int HDR_W      = 1 + 2 * BW_NODE_ID + BW_ID + BW_ADDR + 8 + 3 + 2;
  localparam int HDR_FLITS  = (HDR_W + BW_FLIT - 1) / BW_FLIT;
  localparam int HP         = HDR_FLITS * BW_FLIT;
  localparam int BEAT_W     = 9 * NB;
  localparam int BEAT_FLITS = (BEAT_W + BW_FLIT - 1) / BW_FLIT;
  localparam int BP         = BEAT_FLITS * BW_FLIT;
  localparam int MAXF       = HDR_FLITS > BEAT_FLITS ? HDR_FLITS : BEAT_FLITS;
  localparam int IW         = $clog2(MAXF + 1);

  typedef enum logic [1:0] {IDLE, HDR, WCAP, WSEND} state_t;

  state_t              state, state_d;
  logic                alive;
  logic [HP-1:0]       hdr_sr;
  logic [BP-1:0]       beat_sr;
  logic [IW-1:0]       idx;
  logic [7:0]          beat, len_q;
  logic [HDR_W-1:0]    hdr_vec;
  logic [BEAT_W-1:0]   beat_vec;
  logic                aw_hs, w_hs, flit_valid, fire, hdr_last, beat_last, pkt_last;

  assign hdr_vec = {1'b1, awdst_node_id, src_node_id, awid, awaddr, awlen, awsize, awburst};

  // byte 0 lands at the MSB end, each byte carrying its strobe bit on top
  always_comb begin
    beat_vec = '0;
    for (int i = 0; i < NB; i++) beat_vec[BEAT_W-1-9*i -: 9] = {wstrb[i], wdata[8*i +: 8]};
  end

  always_comb begin
    awready    = alive && state == IDLE;
    wready     = state == WCAP;
    flit_valid = state == HDR || state == WSEND;
    aw_hs      = awvalid && awready;
    w_hs       = wvalid && wready;
    fire       = flit_valid && fni_ready;
    hdr_last   = idx == IW'(HDR_FLITS - 1);
    beat_last  = idx == IW'(BEAT_FLITS - 1);
    pkt_last   = beat == len_q;
    fni_link   = {flit_valid,
                  state == HDR && idx == '0,
                  state == WSEND && beat_last && pkt_last,
                  state == HDR ? hdr_sr[HP-1 -: BW_FLIT] : state == WSEND ? beat_sr[BP-1 -: BW_FLIT] : {BW_FLIT{1'b0}}};
    state_d    = state == IDLE ? (aw_hs ? HDR : IDLE) :
                 state == HDR  ? (fire && hdr_last ? WCAP : HDR) :
                 state == WCAP ? (w_hs ? WSEND : WCAP) :
                                 (fire && beat_last ? (pkt_last ? IDLE : WCAP) : WSEND);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state          <= IDLE;
      alive          <= 1'b0;
      hdr_sr         <= '0;
      beat_sr        <= '0;
      idx            <= '0;
      beat           <= '0;
      len_q          <= '0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_d;
      alive <= 1'b1;
      if (aw_hs) begin
        hdr_sr <= HP'(hdr_vec) << (HP - HDR_W);
        len_q  <= awlen;
        beat   <= '0;
        idx    <= '0;
      end
      if (w_hs) begin
        beat_sr        <= BP'(beat_vec) << (BP - BEAT_W);
        protocol_error <= protocol_error | ((beat == len_q) != wlast);
      end
      if (fire && state == HDR) begin
        hdr_sr <= hdr_sr << BW_FLIT;
        idx    <= hdr_last ? '0 : idx + 1'b1;
      end
      if (fire && state == WSEND) begin
        beat_sr <= beat_sr << BW_FLIT;
        idx     <= beat_last ? '0 : idx + 1'b1;
        if (beat_last && !pkt_last) beat <= beat + 8'd1;
      end
    end
  end
endmodule

// File: doc/munoc_write_request_packetizer.md
# munoc_write_request_packetizer

Master-side network-interface block that packetizes an AXI write request (AW plus W channels) into the flit stream of an FNI link. It is the transmit counterpart of the slave-side write-request depacketizer: its header layout and byte/strobe data packing match what that block unpacks. It sits between a master's AXI write-request port and the request network injection link.

## Interface

Parameters:
- BW_FLIT, 32, flit payload width
- BW_ADDR, 32, AXI address width
- BW_DATA, 32, AXI data width (multiple of 8)
- BW_ID, 4, AXI transaction ID width
- BW_NODE_ID, 4, master and slave node ID width

Derived values:
- HDR_W = 1+2·BW_NODE_ID+BW_ID+BW_ADDR+8+3+2
- HDR_FLITS = ceil(HDR_W/BW_FLIT)
- BEAT_W = 9·BW_DATA/8
- BEAT_FLITS = ceil(BEAT_W/BW_FLIT)

Ports:
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- src_node_id  in  BW_NODE_ID  this master's node ID; static
- awdst_node_id  in  BW_NODE_ID  decoded destination slave node; qualified with awvalid
- awvalid, awready  in/out  1  AW handshake
- awid, awaddr, awlen, awsize, awburst  in  BW_ID/BW_ADDR/8/3/2  AW fields
- wvalid, wready  in/out  1  W handshake
- wdata, wstrb, wlast  in  BW_DATA/BW_DATA/8/1  W fields
- fni_link  out  BW_FLIT+3  {flit_valid, flit_head, flit_tail, flit_payload}
- fni_ready  in  1  network accepts flit when flit_valid && fni_ready
- protocol_error  out  1  sticky; wlast did not match awlen

## Operation

- Header vector, MSB first: {type=1 (write), dst, src, awid, awaddr, awlen, awsize, awburst}.
  - Left-aligned in HDR_FLITS·BW_FLIT bits, zero-padded at the LSBs.
  - Sent as HDR_FLITS flits, most significant slice first.
- Beat vector: for byte i = 0..BW_DATA/8-1, the 9-bit field {wstrb[i], wdata[8i+7:8i]}, with byte 0 at the MSB.
  - Left-aligned and zero-padded to BEAT_FLITS·BW_FLIT bits.
  - Sent as BEAT_FLITS flits, most significant slice first.
- flit_head is 1 only on the first header flit. flit_tail is 1 only on the last flit of beat number awlen (0-based). Packet length comes from the beat counter, not from wlast.
- FSM:
  - IDLE: awready=1. On AW handshake, latch header fields, clear the beat counter, go to HDR.
  - HDR: present header flits, advancing one slice per accepted flit. After the last header flit is accepted, go to WCAP.
  - WCAP: wready=1. On W handshake, latch the beat vector. If (beat==awlen) != wlast, set protocol_error. Go to WSEND.
  - WSEND: present beat flits. After the last beat flit is accepted: if beat==awlen, go to IDLE; else increment beat and go to WCAP.
- awready=0 outside IDLE and wready=0 outside WCAP. No AW is accepted while a packet is in flight, and W beats never run ahead of the header.
- Once flit_valid is 1, the full fni_link stays stable until accepted. flit_valid is never withdrawn.
- protocol_error is cleared only by reset. Packet framing is unaffected by it.

## Timing

- All registered outputs reset to 0 and the FSM resets to IDLE: fni_link=0, wready=0, protocol_error=0.
  - awready is 1 one cycle after reset release. It is a registered or state decode; it must be 0 during reset.
- AW handshake in cycle N: first header flit valid in N+1.
- Each flit is accepted in the cycle when flit_valid && fni_ready. The next flit is presented in the following cycle with no bubble.
- A W handshake in cycle M gives the first beat flit valid in M+1.
- The last flit of a packet accepted in cycle K gives IDLE and awready=1 in K+1.
- Minimum packet time is HDR_FLITS + (awlen+1)·(BEAT_FLITS+1) + 1 cycles.
- fni_ready low holds the current flit. The state and slice index do not advance.
- Reset asserted mid-packet clears everything immediately, with no tail flit emitted. The network side must be reset in the same domain.

## Test plan

- Single beat, default params: dst=3, src=5, awid=0xA, awaddr=0x10000040, awlen=0, awsize=2, awburst=1, wdata=0x44332211, wstrb=0xF, wlast=1, fni_ready=1.
  - Exactly 4 flits: head on flit 0 only, tail on flit 3 only.
  - Flit 0 bits [31:19]=1_0011_0101_1010.
  - Flit 2 payload 0x88C8A674; flit 3 payload 0x40000000.
- Burst awlen=3 with wstrb varying 0xF, 0x1, 0x0, 0x8:
  - 2+8 flits, tail only on the last flit, strobe bits at positions 31/22/13/4 of each first beat flit.
  - protocol_error stays 0.
- fni_ready toggled randomly (50%) during a 4-beat burst: flit sequence identical to the fni_ready=1 run, and fni_link stable while stalled.
- Back-to-back AW: second awvalid held high during the first packet; awready stays 0 until the cycle after the first tail is accepted, then the second packet starts with no gap.
- wlast=1 on beat 1 of an awlen=3 burst: protocol_error=1 from the next cycle, all 4 beats still sent, tail on beat 3.
- rstnn pulled low during HDR: all outputs 0 asynchronously. After release, a fresh single-beat packet is sent correctly.
